// File: rtl/baud_pkg.sv
// Shared constants for the UART baud-clock generator: reset divisor,
// minimum period length and precomputed divisors for common baud rates.
package baud_pkg;

   // 50 MHz / 27.125 = 1.8433 MHz, i.e. 115200 baud x16 oversampling.
   localparam int BAUD_DEF_INT  = 27;
   localparam int BAUD_DEF_FRAC = 2;

   // Shortest legal period; smaller programmed values clamp to this.
   localparam int MIN_DIV = 2;

   // Divisors (1/16 fractional resolution) for 50 MHz, x16 oversampling.
   localparam int DIV_115200X16_INT  = 27;
   localparam int DIV_115200X16_FRAC = 2;
   localparam int DIV_9600X16_INT    = 325;
   localparam int DIV_9600X16_FRAC   = 8;

endpackage

// File: rtl/frac_period_ctr.sv
// Fractional period counter: owns the active divisor, the period counter and
// the fraction accumulator, and reports period end and the half-period point.
module frac_period_ctr
   import baud_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int FRAC_W   = 4,
   parameter int DEF_INT  = BAUD_DEF_INT,
   parameter int DEF_FRAC = BAUD_DEF_FRAC
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              reload_req_i,
   input  logic [CNT_W-1:0]  shadow_int_i,
   input  logic [FRAC_W-1:0] shadow_frac_i,
   output logic              reload_o,
   output logic              period_end_o,
   output logic              upper_half_o
);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [CNT_W:0]    plen_q, plen_d;
   logic [CNT_W-1:0]  act_int_q, act_int_d;
   logic [FRAC_W-1:0] act_frac_q, act_frac_d;
   logic              run_q, run_d;

   logic              start;
   logic              period_end;
   logic [CNT_W-1:0]  new_int;
   logic [FRAC_W-1:0] new_frac;
   logic [CNT_W-1:0]  int_eff;
   logic [FRAC_W:0]   acc_sum;
   logic [CNT_W:0]    half;

   always_comb begin
      // run_q lags en by one cycle so the first period after enable begins
      // with a dedicated start cycle, exactly like the first after reset.
      start      = en_i && !run_q;
      period_end = en_i && run_q && ({1'b0, cnt_q} == plen_q - (CNT_W+1)'(1));
      reload_o   = reload_req_i && (!en_i || start || period_end);

      new_int  = reload_o ? shadow_int_i  : act_int_q;
      new_frac = reload_o ? shadow_frac_i : act_frac_q;
      int_eff  = (new_int < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : new_int;
      acc_sum  = {1'b0, acc_q} + {1'b0, new_frac};

      half         = (plen_q + (CNT_W+1)'(1)) >> 1;
      upper_half_o = run_q && ({1'b0, cnt_q} >= half);
      period_end_o = period_end;

      act_int_d  = new_int;
      act_frac_d = new_frac;
      run_d      = en_i;
      cnt_d      = cnt_q + CNT_W'(1);
      acc_d      = acc_q;
      plen_d     = plen_q;

      if (!en_i) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (start || period_end) begin
         // The period length is fixed here; accumulator carry adds one cycle.
         cnt_d  = '0;
         acc_d  = acc_sum[FRAC_W-1:0];
         plen_d = {1'b0, int_eff} + {{CNT_W{1'b0}}, acc_sum[FRAC_W]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         plen_q     <= (CNT_W+1)'(DEF_INT);
         act_int_q  <= CNT_W'(DEF_INT);
         act_frac_q <= FRAC_W'(DEF_FRAC);
         run_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         plen_q     <= plen_d;
         act_int_q  <= act_int_d;
         act_frac_q <= act_frac_d;
         run_q      <= run_d;
      end
   end

endmodule

// File: rtl/baud_clk_gen.sv
// Fractional baud-clock generator: oversample square wave plus oversample and
// bit strobes, with a shadowed divisor that takes effect on period boundaries.
module baud_clk_gen
   import baud_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int FRAC_W   = 4,
   parameter int OVS      = 16,
   parameter int DEF_INT  = BAUD_DEF_INT,
   parameter int DEF_FRAC = BAUD_DEF_FRAC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CNT_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   output logic              div_pending,
   output logic              clk_out,
   output logic              ovs_tick,
   output logic              bit_tick
);

   localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;

   logic [CNT_W-1:0]  shad_int_q, shad_int_d;
   logic [FRAC_W-1:0] shad_frac_q, shad_frac_d;
   logic              pend_q, pend_d;
   logic [OVS_W-1:0]  ovs_cnt_q, ovs_cnt_d;
   logic              clk_out_q, clk_out_d;
   logic              ovs_tick_q, ovs_tick_d;
   logic              bit_tick_q, bit_tick_d;

   logic              reload;
   logic              period_end;
   logic              upper_half;
   logic              ovs_wrap;

   frac_period_ctr #(
      .CNT_W    (CNT_W),
      .FRAC_W   (FRAC_W),
      .DEF_INT  (DEF_INT),
      .DEF_FRAC (DEF_FRAC)
   ) u_period (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (en),
      .reload_req_i  (pend_q),
      .shadow_int_i  (shad_int_q),
      .shadow_frac_i (shad_frac_q),
      .reload_o      (reload),
      .period_end_o  (period_end),
      .upper_half_o  (upper_half)
   );

   always_comb begin
      // A capture on the reload cycle re-arms the shadow, so the last load wins.
      pend_d      = div_load ? 1'b1 : (reload ? 1'b0 : pend_q);
      shad_int_d  = div_load ? div_int  : shad_int_q;
      shad_frac_d = div_load ? div_frac : shad_frac_q;

      ovs_wrap  = (ovs_cnt_q == OVS_W'(OVS - 1));
      ovs_cnt_d = ovs_cnt_q;
      if (!en) begin
         ovs_cnt_d = '0;
      end else if (period_end) begin
         ovs_cnt_d = ovs_wrap ? '0 : ovs_cnt_q + OVS_W'(1);
      end

      ovs_tick_d = period_end;
      bit_tick_d = period_end && ovs_wrap;
      clk_out_d  = en && upper_half;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shad_int_q  <= CNT_W'(DEF_INT);
         shad_frac_q <= FRAC_W'(DEF_FRAC);
         pend_q      <= 1'b0;
         ovs_cnt_q   <= '0;
         clk_out_q   <= 1'b0;
         ovs_tick_q  <= 1'b0;
         bit_tick_q  <= 1'b0;
      end else begin
         shad_int_q  <= shad_int_d;
         shad_frac_q <= shad_frac_d;
         pend_q      <= pend_d;
         ovs_cnt_q   <= ovs_cnt_d;
         clk_out_q   <= clk_out_d;
         ovs_tick_q  <= ovs_tick_d;
         bit_tick_q  <= bit_tick_d;
      end
   end

   assign div_pending = pend_q;
   assign clk_out     = clk_out_q;
   assign ovs_tick    = ovs_tick_q;
   assign bit_tick    = bit_tick_q;

endmodule

// File: tb/tb_baud_clk_gen.sv
// Directed bench for baud_clk_gen: period lengths, duty split, strobes,
// divisor reload timing, enable gating and reset with a pending load.
module tb_baud_clk_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] div_int;
   logic [3:0]  div_frac;
   logic        div_load;
   logic        div_pending;
   logic        clk_out;
   logic        ovs_tick;
   logic        bit_tick;

   int vec_cnt     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   baud_clk_gen dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .div_int     (div_int),
      .div_frac    (div_frac),
      .div_load    (div_load),
      .div_pending (div_pending),
      .clk_out     (clk_out),
      .ovs_tick    (ovs_tick),
      .bit_tick    (bit_tick)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_div(input int i, input int f);
      div_int  = 16'(i);
      div_frac = 4'(f);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
   endtask

   // Steps until the next ovs_tick; len counts cycles up to and including it.
   task automatic measure(input string tag, output int len, output int lo,
                          output int hi, output int bt, output int pend_lo,
                          output int pend_end);
      len = 0; lo = 0; hi = 0; bt = 0; pend_lo = 0; pend_end = 0;
      while (len < 400) begin
         step();
         len++;
         if (clk_out) hi++; else lo++;
         if (ovs_tick) begin
            bt       = int'(bit_tick);
            pend_end = int'(div_pending);
            break;
         end
         if (!div_pending) pend_lo++;
      end
      if (!ovs_tick) chk({tag, "_timeout"}, 1, 0);
   endtask

   initial begin
      int len, lo, hi, bt, pl, pe, bsum, exp_p;

      rst      = 1'b1;
      en       = 1'b1;
      div_load = 1'b0;
      div_int  = '0;
      div_frac = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_clk_out", int'(clk_out), 0);
      chk("rst_ovs_tick", int'(ovs_tick), 0);
      chk("rst_bit_tick", int'(bit_tick), 0);
      chk("rst_pending", int'(div_pending), 0);
      rst = 1'b0;

      // Default 27.2: first tick on edge 28, then 27s with a 28 every 8th period.
      measure("first", len, lo, hi, bt, pl, pe);
      chk("first_len", len, 28);
      for (int i = 0; i < 16; i++) begin
         exp_p = ((i + 2) % 8 == 0) ? 28 : 27;
         measure("def", len, lo, hi, bt, pl, pe);
         chk($sformatf("def_len_%0d", i), len, exp_p);
         chk($sformatf("def_lo_%0d", i), lo, (exp_p + 1) / 2);
         chk($sformatf("def_hi_%0d", i), hi, exp_p / 2);
         chk($sformatf("def_bit_%0d", i), bt, (i == 14) ? 1 : 0);
      end

      // Load 10.0 one cycle into a 27-cycle period.
      load_div(10, 0);
      chk("int_pend_set", int'(div_pending), 1);
      measure("int_rest", len, lo, hi, bt, pl, pe);
      chk("int_rest_len", len, 26);
      chk("int_rest_pend_lo", pl, 0);
      chk("int_rest_pend_end", pe, 0);
      bsum = 0;
      for (int j = 0; j < 30; j++) begin
         measure("int", len, lo, hi, bt, pl, pe);
         chk($sformatf("int_len_%0d", j), len, 10);
         if (j < 3) begin
            chk($sformatf("int_lo_%0d", j), lo, 5);
            chk($sformatf("int_hi_%0d", j), hi, 5);
         end
         chk($sformatf("int_bit_%0d", j), bt, (j == 13 || j == 29) ? 1 : 0);
         if (j >= 14) bsum += len;
      end
      chk("int_bit_spacing", bsum, 160);

      // Clamp: 1.0 behaves as 2.0.
      load_div(1, 0);
      measure("clamp_rest", len, lo, hi, bt, pl, pe);
      chk("clamp_rest_len", len, 9);
      for (int j = 0; j < 6; j++) begin
         measure("clamp", len, lo, hi, bt, pl, pe);
         chk($sformatf("clamp_len_%0d", j), len, 2);
         chk($sformatf("clamp_lo_%0d", j), lo, 1);
         chk($sformatf("clamp_hi_%0d", j), hi, 1);
      end

      // Back to 27.0, then a mid-period reload to 5.0 at counter 10.
      load_div(27, 0);
      measure("mid_sw", len, lo, hi, bt, pl, pe);
      chk("mid_sw_len", len, 1);
      measure("mid_p27", len, lo, hi, bt, pl, pe);
      chk("mid_p27_len", len, 27);
      chk("mid_p27_lo", lo, 14);
      chk("mid_p27_hi", hi, 13);
      repeat (10) step();
      load_div(5, 0);
      chk("mid_pend_set", int'(div_pending), 1);
      measure("mid_rest", len, lo, hi, bt, pl, pe);
      chk("mid_rest_len", len, 16);
      chk("mid_rest_pend_lo", pl, 0);
      chk("mid_rest_pend_end", pe, 0);
      measure("mid_p5", len, lo, hi, bt, pl, pe);
      chk("mid_p5_len", len, 5);
      chk("mid_p5_lo", lo, 3);
      chk("mid_p5_hi", hi, 2);

      // Load on the cycle the counter holds P-1.
      repeat (4) step();
      div_int  = 16'd8;
      div_frac = 4'd0;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      chk("coll_tick", int'(ovs_tick), 1);
      chk("coll_pend", int'(div_pending), 1);
      measure("coll_old", len, lo, hi, bt, pl, pe);
      chk("coll_old_len", len, 5);
      chk("coll_old_pend_end", pe, 0);
      measure("coll_new", len, lo, hi, bt, pl, pe);
      chk("coll_new_len", len, 8);
      chk("coll_new_lo", lo, 4);
      chk("coll_new_hi", hi, 4);

      // Drop enable in the high half, load while disabled, re-enable.
      repeat (6) step();
      chk("en_pre_clk_out", int'(clk_out), 1);
      en = 1'b0;
      step();
      chk("en_off_clk_out", int'(clk_out), 0);
      chk("en_off_ovs_tick", int'(ovs_tick), 0);
      load_div(12, 0);
      chk("en_off_pend_set", int'(div_pending), 1);
      step();
      chk("en_off_pend_clr", int'(div_pending), 0);
      en = 1'b1;
      measure("en_first", len, lo, hi, bt, pl, pe);
      chk("en_first_len", len, 13);
      measure("en_p12", len, lo, hi, bt, pl, pe);
      chk("en_p12_len", len, 12);
      chk("en_p12_lo", lo, 6);
      chk("en_p12_hi", hi, 6);

      // Reset with a load pending restores 27.2.
      repeat (3) step();
      load_div(5, 0);
      chk("rstp_pend_set", int'(div_pending), 1);
      rst = 1'b1;
      step();
      chk("rstp_pend", int'(div_pending), 0);
      chk("rstp_clk_out", int'(clk_out), 0);
      chk("rstp_ovs_tick", int'(ovs_tick), 0);
      chk("rstp_bit_tick", int'(bit_tick), 0);
      rst = 1'b0;
      measure("rstp_first", len, lo, hi, bt, pl, pe);
      chk("rstp_first_len", len, 28);
      measure("rstp_p27", len, lo, hi, bt, pl, pe);
      chk("rstp_p27_len", len, 27);
      chk("rstp_p27_lo", lo, 14);
      chk("rstp_p27_hi", hi, 13);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule

// File: doc/baud_clk_gen.md
Name: baud_clk_gen

Overview:
- Parametrised fractional baud-clock generator for the UART receiver and transmitter.
- Replaces the fixed divide-by-27 square-wave generator with:
  - a runtime-programmable integer.fraction divisor;
  - glitch-free divisor reload;
  - enable gating;
  - one-cycle oversample and bit strobes alongside the square-wave clock output.
- Runs in the system clock domain. The consumer is the UART bit sampler.

Parameters:
- CNT_W, 16: width of integer divisor and period counter.
- FRAC_W, 4: width of fractional divisor; resolution is 1/2^FRAC_W cycle.
- OVS, 16: oversample periods per bit; must be 2..256.
- DEF_INT, 27: integer divisor after reset.
- DEF_FRAC, 2: fractional divisor after reset. 27 + 2/16 = 27.125 gives 1.8433 MHz from 50 MHz.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- en, input, 1: generator enable.
- div_int, input, CNT_W: integer part of cycles per oversample period.
- div_frac, input, FRAC_W: fractional part of cycles per oversample period.
- div_load, input, 1: one-cycle request to capture div_int/div_frac.
- div_pending, output, 1: captured divisor not yet in effect.
- clk_out, output, 1: oversample-rate square wave.
- ovs_tick, output, 1: one-cycle strobe per oversample period.
- bit_tick, output, 1: one-cycle strobe every OVS oversample periods.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named rst.
- Reset (rst=1 at a clk edge):
  - active divisor := DEF_INT.DEF_FRAC;
  - period counter, fraction accumulator and OVS counter := 0;
  - all outputs := 0.
  - rst overrides en and div_load on the same cycle.
- Period length P:
  - P = int_eff, or int_eff+1 when the fractional accumulator carries.
  - Accumulator (FRAC_W bits) adds frac_eff at each period start. Carry-out lengthens that period by one cycle.
  - int_eff = max(div_int, 2). Values 0 and 1 clamp to 2.
  - Long-run average period = int_eff + frac_eff/2^FRAC_W exactly.
- Period counter and ovs_tick:
  - Counter runs 0..P-1.
  - ovs_tick is registered and is 1 in the cycle after the counter holds P-1.
  - With en held at 1 from reset release, the first ovs_tick occurs on edge P+1 after rst drops. Later ticks follow every P cycles.
- clk_out (registered):
  - 0 while counter < ceil(P/2), 1 otherwise.
  - For P=27: 14 cycles low, 13 high.
  - Same one-cycle latency as ovs_tick.
- OVS counter and bit_tick:
  - OVS counter counts ovs_ticks 0..OVS-1 and wraps.
  - bit_tick asserts in the same cycle as the ovs_tick that wraps the counter from OVS-1 to 0, i.e. every OVS-th tick.
- en=0:
  - Counters and accumulator clear to 0; outputs forced 0 on the next cycle.
  - On en rising, timing restarts exactly as after reset. The active divisor is retained.
- Divisor load:
  - div_load=1 captures div_int/div_frac into a shadow register and sets div_pending.
  - The shadow becomes active at the next period start, i.e. the cycle after the counter holds P-1. div_pending clears in that same cycle.
  - If en=0, the shadow becomes active on the next cycle.
  - A period in progress is never shortened or stretched.
  - Load on the same cycle as a period boundary: the new value applies from the following boundary, not the current one.
  - Back-to-back loads: the last captured value wins.
  - The fractional accumulator is not cleared on load.

Decomposition:
- Package baud_pkg holds:
  - default divisor constants DEF_INT/DEF_FRAC for 50 MHz;
  - the MIN_DIV=2 constant;
  - helper constants for common baud rates, e.g. 115200x16 and 9600x16.
- One sub-module: frac_period_ctr. It owns the period counter, accumulator, clamp and reload, and outputs period_end and the current half-point compare.
- Top-level baud_clk_gen adds the OVS counter, output registers and the load shadow.

Test Plan:
- Reset default: rst for 3 cycles, then en=1 for 2000 cycles.
  - Periods follow a pattern of 27s with one 28 every 8 periods, averaging 27.125.
  - clk_out is low 14 and high 13 on P=27 periods.
- Integer divisor: load 10.0.
  - After the current period ends, ovs_tick occurs every 10 cycles, clk_out is 5 low/5 high, and bit_tick occurs every 160 cycles.
- Clamp: load div_int=1, div_frac=0.
  - Period is 2 cycles, clk_out alternates 1 low/1 high, and there are no zero-length periods.
- Mid-period reload: P=27; pulse div_load with 5.0 when the counter is at 10.
  - The current period still completes at 27.
  - div_pending stays high until the boundary, then the next period is 5.
- Boundary collision: div_load on the cycle the counter holds P-1.
  - The next period still uses the old divisor; the one after uses the new divisor.
- Enable and reset mid-run:
  - Drop en mid-period: outputs go to 0 the next cycle. Raise en again: first ovs_tick occurs P+1 edges later.
  - Assert rst while a load is pending: divisor returns to 27.2 and div_pending=0.
